// File: rtl/rv32m_pkg.sv
// Shared types and constants for the RV32M divide unit.
package rv32m_pkg;

  localparam int DEFAULT_XLEN = 32;

  // Matches funct3[1:0] of DIV/DIVU/REM/REMU: bit0 = unsigned, bit1 = remainder.
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference only if it did not borrow.
module div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   r,
  input  logic         q_msb,
  input  logic [W-1:0] dvsr,
  output logic [W:0]   r_nxt,
  output logic         q_bit
);

  logic [W:0] rs;
  logic [W:0] d;
  // The partial remainder is always below the divisor, so its top bit is zero.
  logic       unused_r_msb;

  assign unused_r_msb = r[W];
  assign rs = {r[W-1:0], q_msb};
  // Subtract as add of inverted divisor with carry-in 1; d[W] set means borrow.
  assign d     = rs + {1'b1, ~dvsr} + {{W{1'b0}}, 1'b1};
  assign q_bit = ~d[W];
  assign r_nxt = q_bit ? d : rs;

endmodule

// File: rtl/rv32_divider.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per CALC cycle; divide-by-zero and signed overflow
// are resolved in the accept cycle and go straight to DONE.
module rv32_divider
  import rv32m_pkg::*;
#(
  parameter  int XLEN  = DEFAULT_XLEN,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            result_valid,
  input  logic            result_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  div_state_e state, state_nxt;

  logic             is_rem_q, neg_q_q, neg_r_q;
  logic [XLEN:0]    r_q;
  logic [XLEN-1:0]  q_q, dvsr_q, result_q;
  logic [CNT_W-1:0] count_q;

  div_op_e          op_e;
  logic             accept, op_signed, op_rem;
  logic             a_neg, b_neg, div_zero, ovf, fast;
  logic [XLEN-1:0]  a_mag, b_mag, fast_res;
  logic             last;

  logic [XLEN:0]    step_r;
  logic             step_q;
  logic [XLEN-1:0]  q_fin, r_fin, q_fix, r_fix;

  assign op_e      = div_op_e'(op);
  assign op_signed = (op_e == OP_DIV) || (op_e == OP_REM);
  assign op_rem    = (op_e == OP_REM) || (op_e == OP_REMU);
  assign accept    = start_valid & start_ready;

  assign a_neg = op_signed & dividend[XLEN-1];
  assign b_neg = op_signed & divisor[XLEN-1];
  assign a_mag = a_neg ? -dividend : dividend;
  assign b_mag = b_neg ? -divisor  : divisor;

  // Both special cases are architecturally defined, no iteration needed.
  assign div_zero = (divisor == '0);
  assign ovf      = op_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}})
                    && (divisor == '1);
  assign fast     = div_zero | ovf;
  assign fast_res = div_zero ? (op_rem ? dividend : '1)
                             : (op_rem ? '0 : dividend);

  div_step #(.W(XLEN)) u_step (
    .r     (r_q),
    .q_msb (q_q[XLEN-1]),
    .dvsr  (dvsr_q),
    .r_nxt (step_r),
    .q_bit (step_q)
  );

  assign last  = (count_q == CNT_W'(XLEN - 1));
  // Final step's outputs feed the sign fix-up directly so DONE holds the answer.
  assign q_fin = {q_q[XLEN-2:0], step_q};
  assign r_fin = step_r[XLEN-1:0];
  assign q_fix = neg_q_q ? -q_fin : q_fin;
  assign r_fix = neg_r_q ? -r_fin : r_fin;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt    = state;
    start_ready  = 1'b0;
    result_valid = 1'b0;
    busy         = 1'b0;
    case (state)
      S_IDLE: begin
        start_ready = 1'b1;
        if (start_valid) state_nxt = fast ? S_DONE : S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy         = 1'b1;
        result_valid = 1'b1;
        if (result_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_rem_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      r_q      <= '0;
      q_q      <= '0;
      dvsr_q   <= '0;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        is_rem_q <= op_rem;
        neg_q_q  <= a_neg ^ b_neg;
        neg_r_q  <= a_neg;
        r_q      <= '0;
        q_q      <= a_mag;
        dvsr_q   <= b_mag;
        count_q  <= '0;
        if (fast) result_q <= fast_res;
      end else if (state == S_CALC) begin
        r_q     <= step_r;
        q_q     <= q_fin;
        count_q <= count_q + CNT_W'(1);
        if (last) result_q <= is_rem_q ? r_fix : q_fix;
      end
    end
  end

  assign result = result_q;

endmodule
